// File: rtl/effect_manager.sv
// effect_manager: turns one-cycle gameplay event pulses into registered
// power-up / curse flags with millisecond expiry timers and a saturating
// 11-bit energy level for the downstream speed selector.
module effect_manager #(
  parameter int TICK_DIV     = 100_000,
  parameter int POWER_UP_MS  = 5000,
  parameter int CURSE_MS     = 8000,
  parameter int ENERGY_INIT  = 1000,
  parameter int ENERGY_MAX   = 2047,
  parameter int ENERGY_BONUS = 200,
  parameter int STEP_COST    = 1
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        step,
  input  logic        power_up_pickup,
  input  logic        curse_hit,
  input  logic        energy_pickup,
  output logic        power_up_active,
  output logic        curse_active,
  output logic [10:0] energy,
  output logic        energy_empty,
  output logic [15:0] power_up_left,
  output logic [15:0] curse_left
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // Energy arithmetic is done 14-bit signed so gain minus cost never wraps.
  localparam logic signed [13:0] COST_NORMAL = 14'(STEP_COST);
  localparam logic signed [13:0] COST_CURSED = 14'(2 * STEP_COST);
  localparam logic signed [13:0] GAIN        = 14'(ENERGY_BONUS);
  localparam logic signed [13:0] E_MAX       = 14'(ENERGY_MAX);

  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [15:0]        pu_next;
  logic [15:0]        cu_next;
  logic signed [13:0] cost;
  logic signed [13:0] gain;
  logic signed [13:0] sum;
  logic [10:0]        energy_next;

  // Shared timer tick: one enabled cycle out of every TICK_DIV.
  assign tick = en && (pre_cnt == TICK_LAST);

  // Free-running prescaler; pickups never touch its phase.
  always_ff @(posedge sysclk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  // Effect timer next-state: power-up reload wins over curse and clears it.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    pu_next = power_up_left;
    cu_next = curse_left;
    if (power_up_pickup) begin
      pu_next = 16'(POWER_UP_MS);
    end else if (tick && (power_up_left != '0)) begin
      pu_next = power_up_left - 16'd1;
    end
    if (power_up_pickup) begin
      cu_next = '0;
    end else if (curse_hit && (power_up_left == '0)) begin
      cu_next = 16'(CURSE_MS);
    end else if (tick && (curse_left != '0)) begin
      cu_next = curse_left - 16'd1;
    end
  end

  // Energy next-state: cost from the flags registered before this edge, clamped.
  always_comb begin
    cost        = '0;
    gain        = '0;
    energy_next = energy;
    if (step) begin
      if (power_up_active) begin
        cost = '0;
      end else if (curse_active) begin
        cost = COST_CURSED;
      end else begin
        cost = COST_NORMAL;
      end
    end
    if (energy_pickup) begin
      gain = GAIN;
    end
    sum = $signed({3'b000, energy}) + gain - cost;
    if (sum < 14'sd0) begin
      energy_next = '0;
    end else if (sum > E_MAX) begin
      energy_next = E_MAX[10:0];
    end else begin
      energy_next = sum[10:0];
    end
  end

  // Output registers: everything holds while the game is not running.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      power_up_left   <= '0;
      curse_left      <= '0;
      power_up_active <= 1'b0;
      curse_active    <= 1'b0;
      energy          <= 11'(ENERGY_INIT);
      energy_empty    <= (ENERGY_INIT == 0);
    end else if (en) begin
      power_up_left   <= pu_next;
      curse_left      <= cu_next;
      power_up_active <= (pu_next != '0);
      curse_active    <= (cu_next != '0);
      energy          <= energy_next;
      energy_empty    <= (energy_next == '0);
    end
  end

endmodule

// File: tb/tb_effect_manager.sv
// Directed bench for effect_manager with a cycle scoreboard: a behavioural
// model pushes the expected outputs when each cycle's stimulus is driven,
// and they are popped and compared one step after the clock edge.
module tb_effect_manager;

  localparam int TD   = 4;
  localparam int PUMS = 3;
  localparam int CUMS = 5;
  localparam int EI   = 10;
  localparam int EMAX = 20;
  localparam int EB   = 5;
  localparam int SC   = 1;

  typedef struct packed {
    logic [10:0] energy;
    logic        pua;
    logic        cua;
    logic        empty;
    logic [15:0] pul;
    logic [15:0] cul;
  } obs_t;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        step;
  logic        power_up_pickup;
  logic        curse_hit;
  logic        energy_pickup;
  logic        power_up_active;
  logic        curse_active;
  logic [10:0] energy;
  logic        energy_empty;
  logic [15:0] power_up_left;
  logic [15:0] curse_left;

  int   tests = 0;
  int   fails = 0;
  obs_t sb[$];

  // Behavioural reference state.
  int m_cnt, m_pu, m_cu, m_energy;
  bit m_pua, m_cua;

  effect_manager #(
    .TICK_DIV(TD), .POWER_UP_MS(PUMS), .CURSE_MS(CUMS), .ENERGY_INIT(EI),
    .ENERGY_MAX(EMAX), .ENERGY_BONUS(EB), .STEP_COST(SC)
  ) dut (
    .sysclk(sysclk), .reset_n(reset_n), .en(en), .step(step),
    .power_up_pickup(power_up_pickup), .curse_hit(curse_hit),
    .energy_pickup(energy_pickup), .power_up_active(power_up_active),
    .curse_active(curse_active), .energy(energy), .energy_empty(energy_empty),
    .power_up_left(power_up_left), .curse_left(curse_left)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pu = 0; m_cu = 0; m_energy = EI; m_pua = 0; m_cua = 0;
  endtask

  // Advance the model by one enabled edge and push the expected outputs.
  task automatic model_push(input bit s, input bit p, input bit c, input bit e);
    bit tick;
    int npu, ncu, cost, nen;
    obs_t x;
    if (en) begin
      tick = (m_cnt == TD - 1);
      if (p) npu = PUMS;
      else if (tick && m_pu > 0) npu = m_pu - 1;
      else npu = m_pu;
      if (p) ncu = 0;
      else if (c && m_pu == 0) ncu = CUMS;
      else if (tick && m_cu > 0) ncu = m_cu - 1;
      else ncu = m_cu;
      cost = !s ? 0 : m_pua ? 0 : m_cua ? 2 * SC : SC;
      nen = m_energy + (e ? EB : 0) - cost;
      if (nen < 0) nen = 0;
      if (nen > EMAX) nen = EMAX;
      m_cnt = tick ? 0 : m_cnt + 1;
      m_pu = npu; m_cu = ncu; m_energy = nen;
      m_pua = (npu != 0); m_cua = (ncu != 0);
    end
    x.energy = 11'(m_energy);
    x.pua    = m_pua;
    x.cua    = m_cua;
    x.empty  = (m_energy == 0);
    x.pul    = 16'(m_pu);
    x.cul    = 16'(m_cu);
    sb.push_back(x);
  endtask

  // Drive one cycle of pulses, then pop the scoreboard and compare.
  task automatic cycle(input bit s, input bit p, input bit c, input bit e);
    obs_t got, want;
    step = s; power_up_pickup = p; curse_hit = c; energy_pickup = e;
    model_push(s, p, c, e);
    @(posedge sysclk);
    #1;
    step = 0; power_up_pickup = 0; curse_hit = 0; energy_pickup = 0;
    got = {energy, power_up_active, curse_active, energy_empty, power_up_left, curse_left};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", got);
    end else begin
      want = sb.pop_front();
      assert (got === want) else begin
        fails++;
        $error("FAIL cycle_state: observed e=%0d pua=%b cua=%b emp=%b pul=%0d cul=%0d expected e=%0d pua=%b cua=%b emp=%b pul=%0d cul=%0d",
               got.energy, got.pua, got.cua, got.empty, got.pul, got.cul,
               want.energy, want.pua, want.cua, want.empty, want.pul, want.cul);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_energy", 32'(energy), EI);
    check("rst_pua", 32'(power_up_active), 0);
    check("rst_cua", 32'(curse_active), 0);
    check("rst_empty", 32'(energy_empty), 0);
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_pu_expire(input string tag);
    int i;
    i = 0;
    while (power_up_active === 1'b1 && i < 20) begin
      cycle(0, 0, 0, 0);
      i++;
    end
    check(tag, 32'(power_up_active), 0);
  endtask

  initial begin
    int n;
    int saved;
    reset_n = 1'b1; en = 1'b1;
    step = 0; power_up_pickup = 0; curse_hit = 0; energy_pickup = 0;
    model_reset();
    #2;

    // 1. Reset and idle.
    do_reset();
    repeat (20) cycle(0, 0, 0, 0);
    check("idle_energy", 32'(energy), 10);
    check("idle_pul", 32'(power_up_left), 0);
    check("idle_cul", 32'(curse_left), 0);

    // 2. Power-up lifetime, steps are free while powered.
    cycle(0, 1, 0, 0);
    check("pu_flag", 32'(power_up_active), 1);
    check("pu_left", 32'(power_up_left), PUMS);
    n = 0;
    while (power_up_active === 1'b1 && n < 20) begin
      cycle(1, 0, 0, 0);
      n++;
    end
    check("pu_high_cycles_in_9_12", 32'(n >= 9 && n <= 12), 1);
    check("pu_steps_free", 32'(energy), 10);

    // 3. Curse cost and power-up immunity.
    cycle(0, 0, 1, 0);
    check("curse_flag", 32'(curse_active), 1);
    cycle(1, 0, 0, 0);
    check("curse_step1", 32'(energy), 8);
    cycle(1, 0, 0, 0);
    check("curse_step2", 32'(energy), 6);
    cycle(0, 1, 0, 0);
    check("pu_clears_curse_left", 32'(curse_left), 0);
    check("pu_clears_curse_flag", 32'(curse_active), 0);
    cycle(0, 0, 1, 0);
    check("curse_immune", 32'(curse_active), 0);
    wait_pu_expire("pu_expire_s3");

    // 4. Saturation at both ends.
    do_reset();
    cycle(0, 0, 0, 1);
    check("sat_pick1", 32'(energy), 15);
    cycle(0, 0, 0, 1);
    check("sat_pick2", 32'(energy), 20);
    repeat (4) cycle(0, 0, 0, 1);
    check("sat_hold", 32'(energy), 20);
    repeat (25) cycle(1, 0, 0, 0);
    check("drain_zero", 32'(energy), 0);
    check("drain_empty", 32'(energy_empty), 1);
    cycle(0, 0, 0, 1);
    repeat (4) cycle(1, 0, 0, 0);
    check("at_one", 32'(energy), 1);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    check("cursed_step_floor", 32'(energy), 0);
    check("cursed_step_empty", 32'(energy_empty), 1);

    // 5. Simultaneous events.
    do_reset();
    cycle(0, 1, 1, 0);
    check("simul_pua", 32'(power_up_active), 1);
    check("simul_cua", 32'(curse_active), 0);
    check("simul_cul", 32'(curse_left), 0);
    wait_pu_expire("pu_expire_s5");
    cycle(1, 0, 0, 1);
    check("step_plus_pick", 32'(energy), 14);

    // 6. Enable freeze, resume, async reset mid-effect.
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    en = 1'b0;
    saved = m_cu;
    for (int i = 0; i < 50; i++) begin
      cycle(i % 3 == 0, i % 7 == 3, i % 5 == 1, i % 4 == 2);
    end
    check("freeze_cul", 32'(curse_left), saved);
    check("freeze_energy", 32'(energy), 14);
    check("freeze_pua", 32'(power_up_active), 0);
    en = 1'b1;
    n = 0;
    while (curse_left === 16'(saved) && n < 8) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("resume_cul", 32'(curse_left), saved - 1);
    check("still_cursed", 32'(curse_active), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_cua", 32'(curse_active), 0);
    check("async_cul", 32'(curse_left), 0);
    check("async_pua", 32'(power_up_active), 0);
    check("async_energy", 32'(energy), EI);
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("post_reset_pu", 32'(power_up_left), PUMS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
